// File: rtl/ibex_hpm_counter_bank.sv
// ibex_hpm_counter_bank
// Machine counter/timer bank: mcycle, minstret and NumCounters general event
// counters (mhpmcounter3..), their mhpmevent selectors and mcountinhibit.
// Owns CSR addresses 0xB00-0xB9F and 0x320-0x33F.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   csr_we_i/addr/wdata CSR write port (final value after read-modify-write)
//   csr_rdata_o         combinational read data of the registered state
//   csr_hit_o           address maps to an implemented CSR of this block
//   instr_ret_i         one instruction retired this cycle
//   event_i             per-cycle event pulses
//   stop_count_i        freezes all counting in the current cycle
//   overflow_o          sticky wrap flags: [0] mcycle, [1] minstret, [2+k] counter k
module ibex_hpm_counter_bank #(
  parameter int unsigned NumCounters  = 10,
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   csr_we_i,
  input  logic [11:0]            csr_addr_i,
  input  logic [31:0]            csr_wdata_i,
  output logic [31:0]            csr_rdata_o,
  output logic                   csr_hit_o,
  input  logic                   instr_ret_i,
  input  logic [NumEvents-1:0]   event_i,
  input  logic                   stop_count_i,
  output logic [NumCounters+1:0] overflow_o
);

  localparam int unsigned NC1 = (NumCounters > 0) ? NumCounters : 1;
  // CSR index i (address bits [4:0]) has a counter when CntMask[i] is set:
  // 0 mcycle, 2 minstret, 3..2+NumCounters general counters. The same mask
  // is the set of writable mcountinhibit bits.
  localparam logic [63:0] ImplFull = (64'd1 << (NumCounters + 3)) - 64'd1;
  localparam logic [31:0] CntMask  = ImplFull[31:0] & 32'hFFFF_FFFD;
  localparam logic [31:0] EvtMask  = CntMask & ~32'h0000_0005;

  logic [4:0]  idx;
  logic        cnt_lo_sel, cnt_hi_sel, evt_sel;
  logic [31:0] we_lo, we_hi;
  logic [31:0] rd_lo  [32];
  logic [31:0] rd_hi  [32];
  logic [31:0] evt_rd [32];
  logic        ovf    [32];

  logic [31:0]          inhibit_q, inhibit_d;
  logic [NumEvents-1:0] mhpmevent_q [NC1];
  logic [NumEvents-1:0] mhpmevent_d [NC1];

  assign idx        = csr_addr_i[4:0];
  assign cnt_lo_sel = (csr_addr_i[11:5] == 7'b1011000);  // 0xB00-0xB1F
  assign cnt_hi_sel = (csr_addr_i[11:5] == 7'b1011100);  // 0xB80-0xB9F
  assign evt_sel    = (csr_addr_i[11:5] == 7'b0011001);  // 0x320-0x33F

  always_comb begin
    we_lo = '0;
    we_hi = '0;
    if (csr_we_i && cnt_lo_sel && CntMask[idx]) we_lo[idx] = 1'b1;
    if (csr_we_i && cnt_hi_sel && CntMask[idx]) we_hi[idx] = 1'b1;
  end

  // Control registers
  always_comb begin
    inhibit_d = inhibit_q;
    if (csr_we_i && evt_sel && (idx == 5'd0)) inhibit_d = csr_wdata_i & CntMask;
    for (int k = 0; k < NC1; k++) begin
      mhpmevent_d[k] = mhpmevent_q[k];
      if (csr_we_i && evt_sel && EvtMask[idx] && (idx == 5'(k + 3)))
        mhpmevent_d[k] = csr_wdata_i[NumEvents-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inhibit_q <= '0;
      for (int k = 0; k < NC1; k++) mhpmevent_q[k] <= '0;
    end else begin
      inhibit_q <= inhibit_d;
      for (int k = 0; k < NC1; k++) mhpmevent_q[k] <= mhpmevent_d[k];
    end
  end

  // One slot per CSR index; unimplemented slots read as zero.
  for (genvar i = 0; i < 32; i++) begin : g_slot
    if (CntMask[i]) begin : g_cnt
      localparam int unsigned W = (i < 3) ? 64 : CounterWidth;
      logic [W-1:0] cnt_q, cnt_d;
      logic         ovf_q, ovf_d;
      logic         inc;
      logic [63:0]  cnt_ext;

      if (i == 0) begin : g_cyc
        assign inc = ~inhibit_q[0] & ~stop_count_i;
      end else if (i == 2) begin : g_ret
        assign inc = instr_ret_i & ~inhibit_q[2] & ~stop_count_i;
      end else begin : g_evt
        // Any number of matching events in a cycle counts once.
        assign inc = (|(event_i & mhpmevent_q[i-3])) & ~inhibit_q[i] & ~stop_count_i;
      end

      // A write loads exactly, suppresses the increment and clears the flag.
      always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (we_lo[i] || we_hi[i]) begin
          if (we_lo[i]) cnt_d[31:0]  = csr_wdata_i;
          if (we_hi[i]) cnt_d[W-1:32] = csr_wdata_i[W-33:0];
          ovf_d = 1'b0;
        end else if (inc) begin
          cnt_d = cnt_q + W'(1);
          if (&cnt_q) ovf_d = 1'b1;
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cnt_q <= '0;
          ovf_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          ovf_q <= ovf_d;
        end
      end

      assign cnt_ext  = 64'(cnt_q);
      assign rd_lo[i] = cnt_ext[31:0];
      assign rd_hi[i] = cnt_ext[63:32];
      assign ovf[i]   = ovf_q;
    end else begin : g_none
      assign rd_lo[i] = '0;
      assign rd_hi[i] = '0;
      assign ovf[i]   = 1'b0;
    end

    if (EvtMask[i]) begin : g_evt_rd
      assign evt_rd[i] = 32'(mhpmevent_q[i-3]);
    end else begin : g_evt_none
      assign evt_rd[i] = '0;
    end
  end

  always_comb begin
    csr_hit_o   = 1'b0;
    csr_rdata_o = '0;
    if (cnt_lo_sel && CntMask[idx]) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = rd_lo[idx];
    end else if (cnt_hi_sel && CntMask[idx]) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = rd_hi[idx];
    end else if (evt_sel && (idx == 5'd0)) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = inhibit_q;
    end else if (evt_sel && EvtMask[idx]) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = evt_rd[idx];
    end
  end

  always_comb begin
    overflow_o    = '0;
    overflow_o[0] = ovf[0];
    overflow_o[1] = ovf[2];
    for (int k = 0; k < NumCounters; k++) overflow_o[2+k] = ovf[3+k];
  end

endmodule

// File: tb/tb_ibex_hpm_counter_bank.sv
module tb_ibex_hpm_counter_bank;
  localparam int NC = 10;
  localparam int CW = 40;
  localparam int NE = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            csr_we_i = 1'b0;
  logic [11:0]     csr_addr_i = '0;
  logic [31:0]     csr_wdata_i = '0;
  logic [31:0]     csr_rdata_o;
  logic            csr_hit_o;
  logic            instr_ret_i = 1'b0;
  logic [NE-1:0]   event_i = '0;
  logic            stop_count_i = 1'b0;
  logic [NC+1:0]   overflow_o;

  ibex_hpm_counter_bank #(.NumCounters(NC), .CounterWidth(CW), .NumEvents(NE)) dut (
    .clk_i(clk), .rst_i(rst), .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_hit_o(csr_hit_o),
    .instr_ret_i(instr_ret_i), .event_i(event_i), .stop_count_i(stop_count_i),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: kind 0 = csr_rdata_o, 1 = csr_hit_o, 2 = overflow_o
  string       nm_q  [$];
  int          kind_q[$];
  logic [31:0] exp_q [$];

  task automatic push(input string n, input int k, input logic [31:0] e);
    nm_q.push_back(n);
    kind_q.push_back(k);
    exp_q.push_back(e);
  endtask

  // Monitor: each negedge, compare every expectation queued for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      string       n;
      int          k;
      logic [31:0] e, a;
      n = nm_q.pop_front();
      k = kind_q.pop_front();
      e = exp_q.pop_front();
      case (k)
        0:       a = csr_rdata_o;
        1:       a = {31'b0, csr_hit_o};
        default: a = 32'(overflow_o);
      endcase
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", n, a, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we_i    = 1'b1;
    csr_addr_i  = a;
    csr_wdata_i = d;
    step();
    csr_we_i    = 1'b0;
  endtask

  task automatic rd(input string n, input logic [11:0] a, input logic [31:0] e);
    csr_addr_i = a;
    push(n, 0, e);
    step();
  endtask

  initial begin
    // Reset state
    csr_addr_i = 12'hB00;
    push("rst_ovf", 2, 32'h0);
    rd("rst_mcycle", 12'hB00, 32'h0);
    rd("rst_inhibit", 12'h320, 32'h0);
    rst = 1'b0;

    // Free run 100 cycles
    repeat (100) @(posedge clk);
    #1;
    push("hit_b00", 1, 32'h1);
    rd("mcycle_lo_100", 12'hB00, 32'd100);
    rd("mcycle_hi_0", 12'hB80, 32'h0);
    rd("minstret_0", 12'hB02, 32'h0);
    push("hit_b01", 1, 32'h0);
    rd("rdata_b01", 12'hB01, 32'h0);

    // mcycle 64-bit wrap and overflow clear
    wr(12'hB00, 32'hFFFF_FFFE);
    wr(12'hB80, 32'hFFFF_FFFF);
    push("mc_ovf_pre0", 2, 32'h0);
    rd("mc_hi_ones", 12'hB80, 32'hFFFF_FFFF);
    push("mc_ovf_pre1", 2, 32'h0);
    rd("mc_lo_ones", 12'hB00, 32'hFFFF_FFFF);
    push("mc_ovf_set", 2, 32'h1);
    rd("mc_hi_wrap", 12'hB80, 32'h0);
    push("mc_ovf_sticky", 2, 32'h1);
    rd("mc_lo_1", 12'hB00, 32'h1);
    wr(12'hB00, 32'h0);
    push("mc_ovf_cleared", 2, 32'h0);
    rd("mc_lo_written", 12'hB00, 32'h0);

    // Counter 0 width truncation and wrap at 40 bits
    wr(12'hB83, 32'hFFFF_FFFF);
    rd("c0_hi_trunc", 12'hB83, 32'h0000_00FF);
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'h323, 32'h1);
    event_i = 16'h0001;
    push("c0_ovf_pre", 2, 32'h0);
    rd("c0_lo_pre", 12'hB03, 32'hFFFF_FFFF);
    event_i = '0;
    push("c0_ovf_set", 2, 32'h4);
    rd("c0_lo_wrap", 12'hB03, 32'h0);
    rd("c0_hi_wrap", 12'hB83, 32'h0);
    wr(12'hB83, 32'h0);
    push("c0_ovf_cleared", 2, 32'h0);
    rd("c0_lo_after_clr", 12'hB03, 32'h0);

    // Event selection: multiple matches count once; non-matching ignored
    wr(12'h323, 32'h5);
    event_i = 16'h0005;
    repeat (4) step();
    event_i = 16'h0002;
    repeat (4) step();
    event_i = '0;
    rd("c0_evt_count", 12'hB03, 32'd4);
    rd("c1_idle", 12'hB04, 32'h0);
    wr(12'h323, 32'hFFFF_FFFF);
    push("hit_323", 1, 32'h1);
    rd("evt3_mask", 12'h323, 32'h0000_FFFF);
    push("hit_321", 1, 32'h0);
    rd("rdata_321", 12'h321, 32'h0);

    // mcountinhibit: writable mask, freeze, next-cycle effect
    wr(12'h320, 32'hFFFF_FFFF);
    rd("inh_mask", 12'h320, 32'h0000_1FFD);
    wr(12'hB00, 32'h1234);
    instr_ret_i = 1'b1;
    event_i     = 16'hFFFF;
    repeat (3) step();
    instr_ret_i = 1'b0;
    event_i     = '0;
    rd("mc_frozen", 12'hB00, 32'h1234);
    rd("mi_frozen", 12'hB02, 32'h0);
    rd("c0_frozen", 12'hB03, 32'd4);
    wr(12'h320, 32'h0);
    rd("inh_old_edge", 12'hB00, 32'h1234);
    rd("inh_released", 12'hB00, 32'h1235);

    // minstret write beats same-cycle increment
    instr_ret_i = 1'b1;
    wr(12'hB02, 32'h10);
    instr_ret_i = 1'b0;
    rd("mi_write_wins", 12'hB02, 32'h10);
    instr_ret_i = 1'b1;
    rd("mi_pre_inc", 12'hB02, 32'h10);
    instr_ret_i = 1'b0;
    rd("mi_inc", 12'hB02, 32'h11);

    // stop_count_i freezes mcycle and minstret without delay
    wr(12'hB00, 32'h500);
    stop_count_i = 1'b1;
    instr_ret_i  = 1'b1;
    for (int i = 0; i < 5; i++) rd("stop_mc", 12'hB00, 32'h500);
    stop_count_i = 1'b0;
    instr_ret_i  = 1'b0;
    rd("stop_mi", 12'hB02, 32'h11);
    rd("stop_release", 12'hB00, 32'h501);

    // Asynchronous reset mid-count
    rst = 1'b1;
    push("rst_mid_ovf", 2, 32'h0);
    rd("rst_mid_mi", 12'hB02, 32'h0);
    rd("rst_mid_evt", 12'h323, 32'h0);
    rst = 1'b0;
    rd("post_rst_mc0", 12'hB00, 32'h0);
    rd("post_rst_mc1", 12'hB00, 32'h1);

    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
